// File: rtl/lsu_mem_stage_pkg.sv
// Shared types, defaults and request decode for the memory-stage load/store unit.
package lsu_mem_stage_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int LINES_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        LD_DATA,
        ST_MERGE,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    function automatic logic mem_signed(input logic [2:0] funct3);
        return ~funct3[2];
    endfunction

    // Illegal encodings, load+store together, or a half/word not on its natural boundary.
    function automatic logic req_fault(input logic       ld,
                                       input logic       st,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal    = (ld & st)
                   | (ld & ((funct3 == 3'b011) | (funct3[2] & funct3[1])))
                   | (st & (funct3[2] | (funct3[1] & funct3[0])));
        misaligned = (ld | st)
                   & (((funct3[1:0] == MEM_H) & addr_lo[0])
                   |  ((funct3[1:0] == MEM_W) & (addr_lo != 2'b00)));
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Lane handling for sub-word accesses: load extract/extend and store read-modify-write merge.
module lsu_mem_stage_align
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ext_data,
    output logic [XLEN-1:0] merged_word
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] lane_mask;
    logic            sgn;

    assign shamt   = {addr_lo, 3'b000};
    assign shifted = word >> shamt;
    assign sgn     = mem_signed(funct3);

    always_comb begin
        ext_data  = word;
        lane_mask = '1;
        case (funct3[1:0])
            MEM_B: begin
                ext_data  = {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]};
                lane_mask = XLEN'(8'hFF) << shamt;
            end
            MEM_H: begin
                ext_data  = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};
                lane_mask = XLEN'(16'hFFFF) << shamt;
            end
            default: begin
                ext_data  = word;
                lane_mask = '1;
            end
        endcase
    end

    assign merged_word = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: one request per handshake, registered-read dram, sub-word stores as RMW.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int LINES = LINES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_fault,
    output logic [XLEN-1:0] dram_addr,
    output logic            dram_load,
    output logic            dram_store,
    output logic [XLEN-1:0] dram_wdata,
    input  logic [XLEN-1:0] dram_rdata
);

    localparam int IDXW = (LINES > 1) ? $clog2(LINES) : 1;

    if (XLEN != 32) begin : g_xlen_chk
        $error("lsu_mem_stage: XLEN must be 32");
    end

    lsu_state_e      state_q, state_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            resp_fault_q, resp_fault_d;

    logic            accept;
    logic            fault_in;
    logic [IDXW-1:0] dram_idx;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] merged_word;
    logic            addr_unused;

    assign addr_unused = ^req_addr;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_rd    = rd_q;
    assign resp_fault = resp_fault_q;

    assign accept   = req_valid & req_ready;
    assign fault_in = req_fault(req_load, req_store, req_funct3, req_addr[1:0]);

    lsu_mem_stage_align #(.XLEN(XLEN)) u_align (
        .word        (dram_rdata),
        .addr_lo     (addr_lo_q),
        .funct3      (funct3_q),
        .wdata       (wdata_q),
        .ext_data    (ext_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_lo_q    <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        dram_load    = 1'b0;
        dram_store   = 1'b0;
        dram_wdata   = '0;
        dram_idx     = idx_q;

        case (state_q)
            IDLE: begin
                dram_idx = req_addr[2 +: IDXW];
                if (accept) begin
                    addr_lo_d    = req_addr[1:0];
                    idx_d        = req_addr[2 +: IDXW];
                    wdata_d      = req_wdata;
                    funct3_d     = req_funct3;
                    rd_d         = req_rd;
                    resp_fault_d = fault_in;
                    resp_data_d  = '0;
                    if (fault_in) begin
                        state_d = RESP;
                    end else if (req_load) begin
                        dram_load = 1'b1;
                        state_d   = LD_DATA;
                    end else if (req_store) begin
                        if (req_funct3[1:0] == MEM_W) begin
                            dram_store = 1'b1;
                            dram_wdata = req_wdata;
                            state_d    = RESP;
                        end else begin
                            // Sub-word store: fetch the word first, merge next cycle.
                            dram_load = 1'b1;
                            state_d   = ST_MERGE;
                        end
                    end else begin
                        resp_data_d = req_wdata;
                        state_d     = RESP;
                    end
                end
            end
            LD_DATA: begin
                resp_data_d = ext_data;
                state_d     = RESP;
            end
            ST_MERGE: begin
                dram_store = 1'b1;
                dram_wdata = merged_word;
                state_d    = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dram_addr = '0;
        dram_addr[IDXW-1:0] = dram_idx;
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage against a behavioural dram and reference access model.
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int LINES = 256;

    logic            clk;
    logic            rst;
    logic            req_valid, req_ready, req_load, req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic [4:0]      req_rd;
    logic            resp_valid, resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            resp_fault;
    logic [XLEN-1:0] dram_addr;
    logic            dram_load, dram_store;
    logic [XLEN-1:0] dram_wdata, dram_rdata;

    lsu_mem_stage #(.XLEN(XLEN), .LINES(LINES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_fault (resp_fault),
        .dram_addr  (dram_addr),
        .dram_load  (dram_load),
        .dram_store (dram_store),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem     [LINES];
    logic [31:0] ref_mem [LINES];

    always @(posedge clk) begin
        if (dram_store) mem[dram_addr[7:0]] <= dram_wdata;
        if (dram_load)  dram_rdata <= mem[dram_addr[7:0]];
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_fault(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] a);
        logic bad;
        bad = 1'b0;
        if (ld && st) bad = 1'b1;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) bad = 1'b1;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) bad = 1'b1;
        if ((ld || st) && f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
        if ((ld || st) && f3[1:0] == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        int          k;
        k = int'(a[1:0]);
        b = w[8*k +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        int          k;
        r = old;
        k = int'(a[1:0]);
        case (f3[1:0])
            2'b00:   r[8*k +: 8] = wd[7:0];
            2'b01:   if (a[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    task automatic do_req(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int hold);
        exp_t        e;
        logic        f;
        logic [7:0]  idx;
        logic [31:0] newword;
        logic        exp_ld, exp_st;
        int          guard, lat;

        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);

        f       = ref_fault(ld, st, f3, a);
        idx     = a[9:2];
        newword = ref_mem[idx];
        e.rd    = rd;
        e.fault = f;
        e.data  = '0;
        e.lat   = 1;
        exp_ld  = 1'b0;
        exp_st  = 1'b0;
        if (f) begin
        end else if (ld) begin
            e.data = ref_load(ref_mem[idx], f3, a);
            e.lat  = 2;
            exp_ld = 1'b1;
        end else if (st) begin
            newword = ref_merge(ref_mem[idx], f3, a, wd);
            if (f3[1:0] == 2'b10) exp_st = 1'b1;
            else begin
                exp_ld = 1'b1;
                e.lat  = 2;
            end
        end else begin
            e.data = wd;
        end
        sb.push_back(e);

        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        req_valid  = 1'b1;
        #1;
        check_eq({tag, "_acc_load"},  {31'd0, dram_load},  {31'd0, exp_ld});
        check_eq({tag, "_acc_store"}, {31'd0, dram_store}, {31'd0, exp_st});
        if (exp_ld || exp_st) check_eq({tag, "_acc_addr"}, dram_addr, {24'd0, idx});
        if (exp_st) check_eq({tag, "_acc_wdata"}, dram_wdata, newword);

        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
        if (!f && st) ref_mem[idx] = newword;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check_eq({tag, "_one_strobe"}, {31'd0, dram_load & dram_store}, 32'd0);
            if (lat == 1 && e.lat == 2 && st) begin
                check_eq({tag, "_rmw_store"}, {31'd0, dram_store}, 32'd1);
                check_eq({tag, "_rmw_addr"}, dram_addr, {24'd0, idx});
                check_eq({tag, "_rmw_wdata"}, dram_wdata, newword);
            end
        end while (!resp_valid && lat < 8);
        check_eq({tag, "_latency"}, 32'(lat), 32'(e.lat));

        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_data"},  resp_data, e.data);
            check_eq({tag, "_rd"},    {27'd0, resp_rd}, {27'd0, e.rd});
            check_eq({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, e.fault});
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
                check_eq({tag, "_hold_data"},  resp_data, e.data);
                check_eq({tag, "_hold_rd"},    {27'd0, resp_rd}, {27'd0, e.rd});
                check_eq({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            end
        end

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_eq({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rl, rs;
        logic [2:0]  rf3;
        logic [31:0] ra;
        int          kind;

        for (int i = 0; i < LINES; i++) mem[i] = $urandom;
        mem[1] = 32'h0000_0000;
        mem[2] = 32'h8899_AABB;
        mem[4] = 32'h1357_9BDF;
        for (int i = 0; i < LINES; i++) ref_mem[i] = mem[i];

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rd     = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_data",  resp_data, 32'd0);
        check_eq("rst_resp_rd",    {27'd0, resp_rd}, 32'd0);
        check_eq("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check_eq("rst_strobes",    {30'd0, dram_load, dram_store}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", {31'd0, req_ready}, 32'd1);

        do_req("lw8",   1, 0, 3'd2, 32'h8, 32'h0, 5'd1, 0);
        do_req("lb9",   1, 0, 3'd0, 32'h9, 32'h0, 5'd2, 0);
        do_req("lbub",  1, 0, 3'd4, 32'hB, 32'h0, 5'd3, 0);
        do_req("lhua",  1, 0, 3'd5, 32'hA, 32'h0, 5'd4, 0);
        do_req("sb5",   0, 1, 3'd0, 32'h5, 32'h1234_56EF, 5'd5, 0);
        do_req("lw4",   1, 0, 3'd2, 32'h4, 32'h0, 5'd6, 0);
        do_req("lh3",   1, 0, 3'd1, 32'h3, 32'h0, 5'd8, 0);
        do_req("f011",  1, 0, 3'd3, 32'h8, 32'h0, 5'd9, 0);
        do_req("ldst",  1, 1, 3'd2, 32'h8, 32'h5555_AAAA, 5'd10, 0);
        do_req("sw_mis",0, 1, 3'd2, 32'h6, 32'h5555_AAAA, 5'd11, 0);
        do_req("nomem", 0, 0, 3'd0, 32'h40, 32'hDEAD_BEEF, 5'd7, 5);
        do_req("wraplw",1, 0, 3'd2, 32'h408, 32'h0, 5'd12, 0);
        do_req("sh_hi", 0, 1, 3'd1, 32'h40A, 32'hFFFF_7654, 5'd13, 0);
        do_req("lh_hi", 1, 0, 3'd1, 32'hA, 32'h0, 5'd14, 0);
        do_req("sw",    0, 1, 3'd2, 32'h30, 32'hA5A5_0F0F, 5'd15, 0);
        do_req("lw30",  1, 0, 3'd2, 32'h30, 32'h0, 5'd16, 0);

        // SH caught by reset while in ST_MERGE: the merge write must never land.
        @(negedge clk);
        req_load   = 1'b0;
        req_store  = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = 32'h10;
        req_wdata  = 32'h0000_CAFE;
        req_rd     = 5'd20;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = 1'b0;
        check_eq("rstmid_pre_store", {31'd0, dram_store}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rstmid_store", {31'd0, dram_store}, 32'd0);
        check_eq("rstmid_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rstmid_rd",    {27'd0, resp_rd}, 32'd0);
        check_eq("rstmid_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        do_req("rstmid_lw", 1, 0, 3'd2, 32'h10, 32'h0, 5'd21, 0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            rl   = (kind >= 1 && kind <= 5) || kind == 9;
            rs   = (kind >= 6);
            rf3  = 3'($urandom_range(0, 7));
            ra   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rf3[1:0] == 2'b10) ra[1:0] = 2'b00;
                else if (rf3[1:0] == 2'b01) ra[0] = 1'b0;
            end
            do_req("rnd", rl, rs, rf3, ra, $urandom, 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
